// File: rtl/instruction_sequencer.sv
// Programmable instruction feeder: loads a program while idle, then streams it
// one instruction per cycle with stall bubbles, a NOP drain tail and run statistics.
module instruction_sequencer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] NOP          = 32'h0000_0000,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          loadValid,
  input  logic [31:0]   loadData,
  output logic          loadReady,
  input  logic          start,
  input  logic          stall,
  input  logic          abort,
  input  logic          clear,
  output logic [31:0]   nextInstruction,
  output logic          issueValid,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   programLength,
  output logic [AW:0]   issuedCount,
  output logic [15:0]   cycleCount
);

  localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e        state_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx_q;
  logic [AW:0]   plen_q;
  logic [AW:0]   issued_q;
  logic [15:0]   cyc_q;
  logic [DW-1:0] drain_q;
  logic [31:0]   instr_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;
  logic          ready_q;

  logic start_ok_c;
  logic load_acc_c;
  logic last_c;
  logic room_c;
  logic room_after_load_c;

  assign start_ok_c        = start && (plen_q != '0);
  assign load_acc_c        = (state_q == S_IDLE) && loadValid && ready_q && !clear && !start_ok_c;
  assign last_c            = ((AW+1)'(idx_q) == (plen_q - (AW+1)'(1)));
  assign room_c            = (plen_q < (AW+1)'(DEPTH));
  assign room_after_load_c = (plen_q != (AW+1)'(DEPTH - 1));

  // Program buffer; contents survive reset as don't-care.
  always_ff @(posedge clk) begin
    if (load_acc_c) mem_q[plen_q[AW-1:0]] <= loadData;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      plen_q   <= '0;
      issued_q <= '0;
      cyc_q    <= '0;
      drain_q  <= '0;
      instr_q  <= NOP;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      instr_q <= NOP;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      // Run-time counter saturates rather than wrapping.
      if ((state_q == S_RUN || state_q == S_DRAIN) && cyc_q != 16'hFFFF)
        cyc_q <= cyc_q + 16'd1;

      case (state_q)
        S_IDLE: begin
          if (clear) begin
            plen_q  <= '0;
            ready_q <= 1'b1;
          end else if (start_ok_c) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            idx_q    <= '0;
            issued_q <= '0;
            cyc_q    <= '0;
          end else if (load_acc_c) begin
            plen_q  <= plen_q + (AW+1)'(1);
            ready_q <= room_after_load_c;
          end else begin
            ready_q <= room_c;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= room_c;
          end else if (!stall) begin
            instr_q  <= mem_q[idx_q];
            valid_q  <= 1'b1;
            idx_q    <= idx_q + AW'(1);
            issued_q <= issued_q + (AW+1)'(1);
            if (last_c) begin
              if (DRAIN_CYCLES == 0) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_DRAIN;
                drain_q <= DW'(DRAIN_CYCLES);
              end
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= room_c;
          end else begin
            drain_q <= drain_q - DW'(1);
            if (drain_q == DW'(1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (clear) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            plen_q  <= '0;
            ready_q <= 1'b1;
          end else if (start) begin
            state_q  <= S_RUN;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            idx_q    <= '0;
            issued_q <= '0;
            cyc_q    <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign nextInstruction = instr_q;
  assign issueValid      = valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign loadReady       = ready_q;
  assign programLength   = plen_q;
  assign issuedCount     = issued_q;
  assign cycleCount      = cyc_q;

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Programmable instruction feeder for the processor's instruction input; replaces hand-timed per-cycle instruction driving with a synthesizable controller.
- Program is loaded into an internal buffer while idle, then streamed one instruction per cycle, with stall bubbles, a pipeline drain period and run statistics.
- Sits between the testbench/loader and the processor's instruction port.

Parameters:
- DEPTH, 16, program buffer entries; power of two, ≥2.
- DRAIN_CYCLES, 4, NOP cycles issued after the last instruction so the pipeline retires it.
- NOP, 32'h0000_0000, instruction driven whenever nothing is issued.
- AW, $clog2(DEPTH), derived index width; not overridden.

Ports:
- clk  input  1  single clock, all state changes on its rising edge.
- resetN  input  1  asynchronous, active-low reset.
- loadValid  input  1  load word present on loadData.
- loadData  input  32  instruction to append to the program.
- loadReady  output  1  buffer accepts a load this cycle.
- start  input  1  begin/restart a run.
- stall  input  1  processor cannot take an instruction; insert a bubble.
- abort  input  1  terminate the run.
- clear  input  1  empty the program buffer.
- nextInstruction  output  32  registered instruction to the processor.
- issueValid  output  1  nextInstruction is a program instruction, not a bubble/NOP.
- busy  output  1  state is RUN or DRAIN.
- done  output  1  state is DONE.
- programLength  output  AW+1  number of loaded words, 0..DEPTH.
- issuedCount  output  AW+1  instructions issued in the current/last run.
- cycleCount  output  16  clock cycles spent in RUN+DRAIN, saturates at 16'hFFFF.

Behaviour:
- Reset (resetN low, asynchronous): state IDLE; nextInstruction=NOP; issueValid, busy, done, loadReady=0 while asserted; programLength, issuedCount, cycleCount, read index, drain counter = 0. Buffer contents are don't-care.
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered or decoded directly from the state.
- IDLE:
  - loadReady=1 iff programLength<DEPTH.
  - loadValid&loadReady writes mem[programLength] and increments programLength.
  - When the buffer is full, loadReady=0 and the word is not written.
  - start with programLength>0: RUN; read index, issuedCount and cycleCount cleared.
  - start with programLength==0 is ignored.
  - start takes priority over a same-cycle load; that load is not written.
- RUN: cycleCount increments every cycle.
  - Edge with stall=0: nextInstruction←mem[index], issueValid←1, index and issuedCount increment.
  - Edge with stall=1: nextInstruction←NOP, issueValid←0, index held.
  - First possible issue is the edge after the start edge.
  - On the edge issuing index programLength-1: go to DRAIN with the drain counter←DRAIN_CYCLES. If DRAIN_CYCLES==0, go straight to DONE.
- DRAIN:
  - nextInstruction=NOP and issueValid=0 from the first DRAIN edge.
  - The counter decrements every cycle and ignores stall.
  - Going from 1 to 0 moves to DONE. cycleCount still increments.
- DONE:
  - done=1; outputs NOP; programLength and the buffer are retained.
  - start re-runs the program from index 0 (counts cleared).
  - clear goes to IDLE with programLength←0.
- abort in RUN or DRAIN: next edge goes to IDLE with NOP, issueValid=0.
  - Program and counts are retained.
  - abort has priority over stall and over the last-issue transition.
- clear is honored in IDLE and DONE only (programLength←0). It has priority over load and start in the same cycle. It is ignored in RUN and DRAIN.
- loadReady=0 in all states except IDLE.
- cycleCount does not wrap; it holds at 16'hFFFF.
- Reset mid-run returns immediately to the reset values above; the program is lost (programLength=0).

Test Plan:
- Load 3 words (0x20080005, 0x20090003, 0x01095020), start, stall=0 → those words appear on 3 consecutive edges after start with issueValid=1; then 4 NOP cycles; then done=1, issuedCount=3, cycleCount=7.
- Same program with stall high for 2 cycles after the first issue → 2 NOP bubbles with issueValid=0, order preserved, cycleCount=9, issuedCount=3.
- Load 17 words with DEPTH=16 → loadReady low after the 16th, programLength=16, and a run issues exactly words 0..15.
- abort on the cycle the 2nd of 3 words issues → next edge NOP, state IDLE, done=0; then start → the run restarts from word 0.
- start with empty buffer → stays IDLE, busy=0. In DONE, start → identical replay; clear → programLength=0 and loadReady=1.
- resetN low mid-RUN (asynchronous, between edges) → nextInstruction=NOP and busy=0 immediately, without waiting for a clock edge.
